pdm_cic_decimator: RTL and testbench

// Parametrised microphone front end. Generates the PDM mic clock and samples the 1-bit mic stream.

---
 rtl/pdm_cic_decimator.sv | 130 +++++++++++++
 tb/tb_pdm_cic_decimator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: mic clock generation, bit capture, N-stage CIC decimation,
// saturation to OUT_WIDTH signed PCM and 3-bit volume scaling.
module pdm_cic_decimator #(
    parameter int CLK_DIV   = 32,
    parameter int ORDER     = 4,
    parameter int DEC_LOG2  = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en_in,
    input  logic [2:0]           vol_in,
    input  logic                 mic_data_in,
    output logic                 mic_clk_out,
    output logic                 pdm_tick_out,
    output logic                 sample_valid_out,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 clip_out
);

    localparam int W     = ORDER * DEC_LOG2 + 2;
    localparam int SHIFT = ORDER * DEC_LOG2 + 1 - OUT_WIDTH;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int SET_W = $clog2(ORDER + 1);

    localparam logic signed [W-1:0] SMAX = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                 w_clr;
    logic [DIV_W-1:0]     r_div;
    logic                 r_mic_clk;
    logic                 r_mic_clk_d;
    logic                 w_tick;
    logic signed [1:0]    r_bit;
    logic                 r_upd;
    logic [DEC_LOG2-1:0]  r_tcnt;
    logic                 r_dec;
    logic [SET_W-1:0]     r_settle;
    logic signed [W-1:0]  r_int [ORDER];
    logic signed [W-1:0]  r_dly [ORDER];
    logic signed [W-1:0]  w_din [ORDER];
    logic signed [W-1:0]  w_c;
    logic signed [W-1:0]  w_s;
    logic signed [OUT_WIDTH-1:0] w_sat;
    logic signed [OUT_WIDTH-1:0] w_vol;
    logic                 w_clip;
    logic [2:0]           w_sh;

    assign w_clr        = rst_in | ~en_in;
    assign w_tick       = r_mic_clk & ~r_mic_clk_d;
    assign mic_clk_out  = r_mic_clk;
    assign pdm_tick_out = w_tick;

    // Comb chain is evaluated combinationally on the strobe cycle so the scaled
    // sample can be registered in the same cycle (valid 3 cycles after the tick).
    always_comb begin
        logic signed [W-1:0] acc;
        acc = r_int[ORDER-1];
        for (int unsigned k = 0; k < ORDER; k++) begin
            w_din[k] = acc;
            acc      = acc - r_dly[k];
        end
        w_c    = acc;
        w_s    = w_c >>> SHIFT;
        w_clip = 1'b0;
        w_sat  = w_s[OUT_WIDTH-1:0];
        if (w_s > SMAX) begin
            w_sat  = SMAX[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_s < SMIN) begin
            w_sat  = SMIN[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end
        w_sh  = 3'd7 - vol_in;
        w_vol = w_sat >>> w_sh;
    end

    always_ff @(posedge clk_in) begin
        if (w_clr) begin
            r_div            <= '0;
            r_mic_clk        <= 1'b0;
            r_mic_clk_d      <= 1'b0;
            r_bit            <= '0;
            r_upd            <= 1'b0;
            r_tcnt           <= '0;
            r_dec            <= 1'b0;
            r_settle         <= '0;
            sample_valid_out <= 1'b0;
            sample_out       <= '0;
            clip_out         <= 1'b0;
            for (int unsigned k = 0; k < ORDER; k++) begin
                r_int[k] <= '0;
                r_dly[k] <= '0;
            end
        end else begin
            r_div       <= (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
            r_mic_clk   <= (r_div < DIV_W'(CLK_DIV / 2));
            r_mic_clk_d <= r_mic_clk;

            r_upd <= w_tick;
            if (w_tick)
                r_bit <= mic_data_in ? 2'sd1 : -2'sd1;

            r_dec <= 1'b0;
            if (r_upd) begin
                // Integrators wrap in two's complement by design.
                r_int[0] <= r_int[0] + {{(W-2){r_bit[1]}}, r_bit};
                for (int unsigned k = 1; k < ORDER; k++)
                    r_int[k] <= r_int[k] + r_int[k-1];
                r_tcnt <= r_tcnt + 1'b1;
                r_dec  <= &r_tcnt;
            end

            sample_valid_out <= 1'b0;
            clip_out         <= 1'b0;
            if (r_dec) begin
                for (int unsigned k = 0; k < ORDER; k++)
                    r_dly[k] <= w_din[k];
                if (r_settle == SET_W'(ORDER)) begin
                    sample_valid_out <= 1'b1;
                    sample_out       <= w_vol;
                    clip_out         <= w_clip;
                end else begin
                    r_settle <= r_settle + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator, run with a shortened decimation ratio (R=16)
// so every scenario fits in a short run; expected PCM values match the default build.
module tb_pdm_cic_decimator;

    localparam int CLK_DIV   = 32;
    localparam int ORDER     = 4;
    localparam int DEC_LOG2  = 4;
    localparam int OUT_WIDTH = 16;
    localparam int R         = 1 << DEC_LOG2;
    localparam int LIMIT     = 20000;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 en_in;
    logic [2:0]           vol_in;
    logic                 mic_data_in;
    logic                 mic_clk_out;
    logic                 pdm_tick_out;
    logic                 sample_valid_out;
    logic [OUT_WIDTH-1:0] sample_out;
    logic                 clip_out;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  alt_mode = 1'b0;

    pdm_cic_decimator #(
        .CLK_DIV   (CLK_DIV),
        .ORDER     (ORDER),
        .DEC_LOG2  (DEC_LOG2),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .en_in            (en_in),
        .vol_in           (vol_in),
        .mic_data_in      (mic_data_in),
        .mic_clk_out      (mic_clk_out),
        .pdm_tick_out     (pdm_tick_out),
        .sample_valid_out (sample_valid_out),
        .sample_out       (sample_out),
        .clip_out         (clip_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advances at negedges until a valid pulse; reports ticks seen, cycles since the
    // last tick and total cycles waited. Alternating mode flips the mic bit on each tick.
    task automatic wait_valid(output int ticks, output int since, output int cycles);
        bit got;
        ticks = 0; since = 0; cycles = 0; got = 1'b0;
        while (!got && cycles < LIMIT) begin
            @(negedge clk_in);
            cycles++;
            since++;
            if (pdm_tick_out) begin
                ticks++;
                since = 0;
                if (alt_mode) mic_data_in = ~mic_data_in;
            end
            if (sample_valid_out) got = 1'b1;
        end
        check("valid_timeout", int'(got), 1);
    endtask

    task automatic run_case(input string tag, input logic mic, input bit alt,
                            input logic [2:0] vol, input int exp_s, input int exp_c);
        int ticks, since, cycles;
        @(negedge clk_in);
        en_in = 1'b0;
        @(negedge clk_in);
        mic_data_in = mic;
        alt_mode    = alt;
        vol_in      = vol;
        en_in       = 1'b1;
        wait_valid(ticks, since, cycles);
        check({tag, "_first_ticks"}, ticks, 5 * R);
        check({tag, "_latency"}, since, 3);
        check({tag, "_sample1"}, int'($signed(sample_out)), exp_s);
        check({tag, "_clip1"}, int'(clip_out), exp_c);
        @(negedge clk_in);
        check({tag, "_valid_pulse"}, int'(sample_valid_out), 0);
        check({tag, "_clip_pulse"}, int'(clip_out), 0);
        check({tag, "_hold"}, int'($signed(sample_out)), exp_s);
        wait_valid(ticks, since, cycles);
        check({tag, "_spacing"}, cycles + 1, R * CLK_DIV);
        check({tag, "_sample2"}, int'($signed(sample_out)), exp_s);
        check({tag, "_clip2"}, int'(clip_out), exp_c);
    endtask

    initial begin
        int ticks, since, cycles, bad;
        rst_in = 1'b1; en_in = 1'b0; vol_in = 3'd7; mic_data_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_mic_clk", int'(mic_clk_out), 0);
        check("rst_tick", int'(pdm_tick_out), 0);
        check("rst_valid", int'(sample_valid_out), 0);
        check("rst_sample", int'(sample_out), 0);
        check("rst_clip", int'(clip_out), 0);

        // Mic clock pattern from release: high for div counts 0..15, tick on count 0.
        rst_in = 1'b0; en_in = 1'b1;
        for (int n = 1; n <= 2 * CLK_DIV; n++) begin
            int m;
            @(negedge clk_in);
            m = (n - 1) % CLK_DIV;
            check("clk_pattern", int'({mic_clk_out, pdm_tick_out}),
                  int'({m < CLK_DIV / 2, m == 0}));
        end

        en_in = 1'b0;
        bad = 0;
        for (int n = 0; n < 2 * CLK_DIV; n++) begin
            @(negedge clk_in);
            if (mic_clk_out || pdm_tick_out) bad++;
        end
        check("en_off_activity", bad, 0);

        run_case("ones", 1'b1, 1'b0, 3'd7, 32767, 1);
        run_case("zeros", 1'b0, 1'b0, 3'd7, -32768, 0);
        run_case("alt", 1'b1, 1'b1, 3'd7, 0, 0);
        run_case("vol3", 1'b1, 1'b0, 3'd3, 2047, 1);

        // Volume change applies to the next sample only; then reset mid-frame.
        @(negedge clk_in);
        en_in = 1'b0;
        @(negedge clk_in);
        mic_data_in = 1'b1; alt_mode = 1'b0; vol_in = 3'd7; en_in = 1'b1;
        wait_valid(ticks, since, cycles);
        check("mid_sample", int'($signed(sample_out)), 32767);
        vol_in = 3'd3;
        @(negedge clk_in);
        check("vol_no_effect", int'($signed(sample_out)), 32767);
        ticks = 0;
        for (int n = 0; n < LIMIT && ticks < R / 2; n++) begin
            @(negedge clk_in);
            if (pdm_tick_out) ticks++;
        end
        check("mid_ticks", ticks, R / 2);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("midrst_sample", int'(sample_out), 0);
        check("midrst_mic_clk", int'(mic_clk_out), 0);
        check("midrst_valid", int'(sample_valid_out), 0);
        wait_valid(ticks, since, cycles);
        check("midrst_ticks", ticks, 5 * R);
        check("midrst_latency", since, 3);
        check("midrst_sample2", int'($signed(sample_out)), 2047);
        check("midrst_clip2", int'(clip_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
